uart_fp_word_rx: RTL and testbench



---
 rtl/uart_fp_word_rx_if.sv | 33 +++
 rtl/uart_fp_word_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_fp_word_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_fp_word_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fp_word_rx_if
// Purpose  : valid/ready word channel between the UART word receiver and the
//            consumer of signed fixed-point words.
// Signals  : word_data  - assembled word (WIDTH bits), stable while valid
//            word_valid - word available
//            word_ready - consumer accepts on valid && ready at clk rise
// Modports : master (producer side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fp_word_rx_if #(
  parameter int WIDTH = 12
) ();

  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_fp_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_fp_word_rx
// Purpose  : 8N1 UART receiver that packs two consecutive good bytes
//            (low byte first) into one signed fixed-point word of width
//            fp_integer_width+fp_fract_width and offers it on a valid/ready
//            channel. Framing errors and overruns are flagged as one-cycle
//            pulses.
// Ports    : clk       - system clock
//            rst       - synchronous reset, active high
//            rx        - asynchronous UART line, idle high
//            word_bus  - master side of the word channel (data/valid/ready)
//            frame_err - one-cycle pulse, stop bit sampled low
//            overrun   - one-cycle pulse, word dropped because the previous
//                        word was still unaccepted
//            busy      - receiver mid-frame or low byte held
// Revision : 1.0 - initial release
// ============================================================================
module uart_fp_word_rx #(
  parameter int fp_integer_width = 2,
  parameter int fp_fract_width   = 10,
  parameter int clock_frequency  = 12000000,
  parameter int uart_baud_rate   = 9600
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          rx,
  uart_fp_word_rx_if.master  word_bus,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  // Word width, legal range 9..16: the high byte always contributes at least
  // one bit and never more than eight.
  localparam int c_w        = fp_integer_width + fp_fract_width;
  localparam int c_hi_bits  = c_w - 8;
  localparam int c_baud_div = clock_frequency / uart_baud_rate;
  localparam int c_half_div = c_baud_div / 2;
  localparam int c_cnt_w    = (c_baud_div > 2) ? $clog2(c_baud_div) : 1;

  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(c_baud_div - 1);
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(c_half_div - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Line synchronizer. r_rx_prev holds the previous synchronized value so a
  // start is only recognised on a genuine 1->0 transition; after a framing
  // error with the line still low, the line must return high first.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver FSM: state register
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  state_t              w_state_next;
  logic [c_cnt_w-1:0]  w_cnt_next;
  logic [2:0]          w_bit_next;
  logic [7:0]          w_shift_next;
  logic                w_byte_good;
  logic                w_byte_bad;
  logic                w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver FSM: next state and strobes. The counter is loaded on entry to
  // each bit and the bit is acted on when it reaches zero, so every sample
  // lands mid-bit relative to the start edge of this frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_byte_good  = 1'b0;
    w_byte_bad   = 1'b0;
    w_tick       = (r_cnt == '0);

    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_next = S_START;
          w_cnt_next   = c_half_load;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            // Line back high at mid start bit: a glitch, not a frame.
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DATA;
            w_cnt_next   = c_full_load;
            w_bit_next   = 3'd0;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      S_DATA: begin
        if (w_tick) begin
          w_shift_next = {r_rx_s, r_shift[7:1]};
          w_cnt_next   = c_full_load;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_bit_next   = 3'd0;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      S_STOP: begin
        if (w_tick) begin
          w_byte_good  = r_rx_s;
          w_byte_bad   = !r_rx_s;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Word assembler and output channel. The word completes in the same edge
  // that accepts the high byte, so word_valid rises one cycle after the
  // mid-stop sample. A load in the handshake cycle takes precedence over the
  // clear, keeping word_valid high with the new word.
  // --------------------------------------------------------------------------
  logic           r_ptr_high;
  logic [7:0]     r_low_byte;
  logic [c_w-1:0] r_word_data;
  logic           r_word_valid;
  logic           r_frame_err;
  logic           r_overrun;
  logic           w_accept;

  assign w_accept = r_word_valid && word_bus.word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_high   <= 1'b0;
      r_low_byte   <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_byte_bad;
      r_overrun   <= 1'b0;

      if (w_accept) begin
        r_word_valid <= 1'b0;
      end

      if (w_byte_bad) begin
        // A bad byte also invalidates any held low byte.
        r_ptr_high <= 1'b0;
      end else if (w_byte_good) begin
        if (!r_ptr_high) begin
          r_low_byte <= r_shift;
          r_ptr_high <= 1'b1;
        end else begin
          r_ptr_high <= 1'b0;
          if (!r_word_valid || word_bus.word_ready) begin
            r_word_data  <= {r_shift[c_hi_bits-1:0], r_low_byte};
            r_word_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign word_bus.word_data  = r_word_data;
  assign word_bus.word_valid = r_word_valid;
  assign frame_err           = r_frame_err;
  assign overrun             = r_overrun;
  assign busy                = (r_state != S_IDLE) || r_ptr_high;

endmodule
`default_nettype wire

// File: tb/tb_uart_fp_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fp_word_rx
// Purpose  : self-checking bench for uart_fp_word_rx. Expected words are
//            queued as frames are sent and compared at each handshake.
//            A short bit period keeps the run small.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fp_word_rx;

  localparam int c_clk_hz = 3200000;
  localparam int c_baud   = 100000;
  localparam int c_bd     = c_clk_hz / c_baud;   // 32 clocks per bit
  localparam int c_w      = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_fp_word_rx_if #(.WIDTH(c_w)) word_bus ();

  uart_fp_word_rx #(
    .fp_integer_width (2),
    .fp_fract_width   (10),
    .clock_frequency  (c_clk_hz),
    .uart_baud_rate   (c_baud)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .word_bus  (word_bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_hs   = 0;
  int n_ferr = 0;
  int n_ovr  = 0;

  logic [c_w-1:0] sb_q[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: counts pulse-high cycles and scores every accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (word_bus.word_valid && word_bus.word_ready) begin
        n_hs++;
        check_value("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check_value("word_data", 32'(word_bus.word_data), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (c_bd) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (2 * c_bd) tick();
  endtask

  task automatic wait_hs(input int target, input string tag);
    int k;
    k = 0;
    while (n_hs < target && k < 2000) begin
      tick();
      k++;
    end
    check_value(tag, 32'(n_hs >= target), 32'd1);
  endtask

  int hs0, fe0, ov0;

  initial begin
    word_bus.word_ready = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_value("rst_valid", 32'(word_bus.word_valid), 32'd0);
    check_value("rst_data",  32'(word_bus.word_data),  32'd0);
    check_value("rst_ferr",  32'(frame_err),           32'd0);
    check_value("rst_ovr",   32'(overrun),             32'd0);
    check_value("rst_busy",  32'(busy),                32'd0);
    tick();

    // +1.0 in Q2.10, consumer always ready.
    hs0 = n_hs; fe0 = n_ferr; ov0 = n_ovr;
    sb_q.push_back(12'h400);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    wait_hs(hs0 + 1, "t1_handshake");
    repeat (4) tick();
    check_value("t1_one_pulse", 32'(n_hs - hs0), 32'd1);
    check_value("t1_ferr", 32'(n_ferr - fe0), 32'd0);
    check_value("t1_ovr",  32'(n_ovr - ov0),  32'd0);
    check_value("t1_busy", 32'(busy), 32'd0);

    // Upper nibble of the high byte ignored; word held until accepted.
    word_bus.word_ready = 1'b0;
    hs0 = n_hs;
    sb_q.push_back(12'h234);
    send_byte(8'h34, 1'b1);
    send_byte(8'hF2, 1'b1);
    repeat (2000) tick();
    @(negedge clk);
    check_value("t2_held_valid", 32'(word_bus.word_valid), 32'd1);
    check_value("t2_held_data",  32'(word_bus.word_data),  32'h234);
    tick();
    word_bus.word_ready = 1'b1;
    tick();
    @(negedge clk);
    check_value("t2_valid_cleared", 32'(word_bus.word_valid), 32'd0);
    check_value("t2_handshake", 32'(n_hs - hs0), 32'd1);
    tick();

    // Overrun: second word completes while the first is unaccepted.
    word_bus.word_ready = 1'b0;
    hs0 = n_hs; ov0 = n_ovr;
    sb_q.push_back(12'h001);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    check_value("t3_ovr_pulses", 32'(n_ovr - ov0), 32'd1);
    check_value("t3_kept_data",  32'(word_bus.word_data), 32'h001);
    check_value("t3_no_hs_yet",  32'(n_hs - hs0), 32'd0);
    tick();
    word_bus.word_ready = 1'b1;
    wait_hs(hs0 + 1, "t3_handshake");
    repeat (4) tick();
    check_value("t3_valid_after", 32'(word_bus.word_valid), 32'd0);

    // Framing error drops the byte; following pair forms the next word.
    hs0 = n_hs; fe0 = n_ferr;
    send_byte(8'hAA, 1'b0);
    check_value("t4_ferr_pulse", 32'(n_ferr - fe0), 32'd1);
    sb_q.push_back(12'h155);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_hs(hs0 + 1, "t4_handshake");
    check_value("t4_ferr_total", 32'(n_ferr - fe0), 32'd1);

    // Short low glitch on an idle line.
    hs0 = n_hs; fe0 = n_ferr;
    rx = 1'b0;
    repeat (8) tick();
    rx = 1'b1;
    repeat (3 * c_bd) tick();
    check_value("t5_ferr", 32'(n_ferr - fe0), 32'd0);
    check_value("t5_no_word", 32'(n_hs - hs0), 32'd0);
    check_value("t5_busy", 32'(busy), 32'd0);

    // Reset in the middle of the high byte's data bits.
    send_byte(8'h11, 1'b1);
    check_value("t6_busy_held_low", 32'(busy), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (c_bd / 2) tick();
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_value("t6_rst_valid", 32'(word_bus.word_valid), 32'd0);
    check_value("t6_rst_data",  32'(word_bus.word_data),  32'd0);
    check_value("t6_rst_busy",  32'(busy),                32'd0);
    check_value("t6_rst_ferr",  32'(frame_err),           32'd0);
    tick();
    repeat (12 * c_bd) tick();
    hs0 = n_hs;
    sb_q.push_back(12'hFFF);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_hs(hs0 + 1, "t6_handshake");

    repeat (4) tick();
    check_value("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
